// File: rtl/modrm_fetch.sv
// ModRM / effective-address fetch-and-writeback sequencer for the 8-bit-bus x86 core.
// Latency: start->done = 1 + disp bytes + operand bytes cycles of bus ownership; done pulses in the first idle cycle.
// Backpressure: none; the core must hand over the byte bus while busy is high. Requests are ignored unless idle.
//
// Ports:
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   start / wb_start       begin a ModRM fetch / a writeback to the last computed address
//   opsz                   operand size (0 byte, 1 word, 2 dword)
//   override, seg_ovr      segment override prefix and its segment value
//   cs, ds, ss, ip_in      segment registers and IP of the ModRM byte
//   bx, bp, si, di         base/index registers
//   wb_data                little-endian writeback data
//   data                   bus read data (valid in the same cycle as address)
//   address, out, wren     byte bus driven by this unit while busy
//   busy, done             bus ownership and one-cycle completion pulse
//   modrm, is_mem, eff, seg, mem_val, ip_out   fetch results, held until the next start
module modrm_fetch #(
  parameter int ADDR_W    = 20,
  parameter int MAX_BYTES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   wb_start,
  input  logic [1:0]             opsz,
  input  logic                   override,
  input  logic [15:0]            seg_ovr,
  input  logic [15:0]            cs,
  input  logic [15:0]            ds,
  input  logic [15:0]            ss,
  input  logic [15:0]            ip_in,
  input  logic [15:0]            bx,
  input  logic [15:0]            bp,
  input  logic [15:0]            si,
  input  logic [15:0]            di,
  input  logic [8*MAX_BYTES-1:0] wb_data,
  input  logic [7:0]             data,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             out,
  output logic                   wren,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             modrm,
  output logic                   is_mem,
  output logic [15:0]            eff,
  output logic [15:0]            seg,
  output logic [8*MAX_BYTES-1:0] mem_val,
  output logic [15:0]            ip_out
);

  localparam int DW = 8 * MAX_BYTES;
  // Sum is formed at least 20 bits wide so seg*16+off never loses its carry before truncation.
  localparam int SW = (ADDR_W > 20) ? ADDR_W : 20;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MODRM   = 3'd1;
  localparam logic [2:0] S_DISP_LO = 3'd2;
  localparam logic [2:0] S_DISP_HI = 3'd3;
  localparam logic [2:0] S_DISP8   = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;

  logic [2:0]        state_q,   state_d;
  logic [15:0]       ip_q,      ip_d;
  logic [2:0]        nbytes_q,  nbytes_d;
  logic              ovr_q,     ovr_d;
  logic [15:0]       seg_ovr_q, seg_ovr_d;
  logic [7:0]        modrm_q,   modrm_d;
  logic              is_mem_q,  is_mem_d;
  logic [15:0]       eff_q,     eff_d;
  logic [15:0]       seg_q,     seg_d;
  logic [DW-1:0]     mem_val_q, mem_val_d;
  logic [DW-1:0]     wb_q,      wb_d;
  logic [1:0]        cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic              done_q,    done_d;

  logic [1:0]        mod_w;
  logic [2:0]        rm_w;
  logic [15:0]       base_w;
  logic              use_ss_w;
  logic              last_w;
  logic [15:0]       data_off_w;
  logic [ADDR_W-1:0] bus_addr_w;
  logic [7:0]        out_w;

  function automatic logic [ADDR_W-1:0] phys(input logic [15:0] s, input logic [15:0] off);
    logic [SW-1:0] sum;
    sum = SW'({s, 4'h0}) + SW'(off);
    return sum[ADDR_W-1:0];
  endfunction

  // Dword requests fall back to word transfers when the unit is built for 2-byte operands.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = (MAX_BYTES >= 4) ? 3'd4 : 3'd2;
    endcase
    return n;
  endfunction

  always_comb begin
    // ModRM decode works straight off the bus byte in the MODRM cycle.
    mod_w = data[7:6];
    rm_w  = data[2:0];
    case (rm_w)
      3'd0:    base_w = bx + si;
      3'd1:    base_w = bx + di;
      3'd2:    base_w = bp + si;
      3'd3:    base_w = bp + di;
      3'd4:    base_w = si;
      3'd5:    base_w = di;
      3'd6:    base_w = bp;
      default: base_w = bx;
    endcase
    // mod=00 rm=110 is the direct-address form: no base, disp16 only.
    if (mod_w == 2'b00 && rm_w == 3'd6) base_w = 16'h0000;
    use_ss_w = (mod_w != 2'b11) &&
               ((rm_w == 3'd2) || (rm_w == 3'd3) || (rm_w == 3'd6 && mod_w != 2'b00));

    last_w     = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
    // Offset arithmetic wraps at 16 bits before the segment is applied.
    data_off_w = eff_q + {14'd0, cnt_q};

    out_w = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (cnt_q == 2'(k)) out_w = wb_q[8*k +: 8];
    end

    case (state_q)
      S_MODRM, S_DISP_LO, S_DISP_HI, S_DISP8: bus_addr_w = phys(cs, ip_q);
      S_READ, S_WRITE:                         bus_addr_w = phys(seg_q, data_off_w);
      default:                                 bus_addr_w = addr_q;
    endcase

    state_d   = state_q;
    ip_d      = ip_q;
    nbytes_d  = nbytes_q;
    ovr_d     = ovr_q;
    seg_ovr_d = seg_ovr_q;
    modrm_d   = modrm_q;
    is_mem_d  = is_mem_q;
    eff_d     = eff_q;
    seg_d     = seg_q;
    mem_val_d = mem_val_q;
    wb_d      = wb_q;
    cnt_d     = cnt_q;
    addr_d    = bus_addr_w;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ip_d      = ip_in;
          nbytes_d  = size_bytes(opsz);
          ovr_d     = override;
          seg_ovr_d = seg_ovr;
          mem_val_d = '0;
          state_d   = S_MODRM;
        end else if (wb_start) begin
          nbytes_d = size_bytes(opsz);
          wb_d     = wb_data;
          cnt_d    = 2'd0;
          state_d  = S_WRITE;
        end
      end
      S_MODRM: begin
        modrm_d  = data;
        is_mem_d = (mod_w != 2'b11);
        eff_d    = base_w;
        seg_d    = ovr_q ? seg_ovr_q : (use_ss_w ? ss : ds);
        ip_d     = ip_q + 16'd1;
        cnt_d    = 2'd0;
        if (mod_w == 2'b11) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if ((mod_w == 2'b00 && rm_w == 3'd6) || mod_w == 2'b10) begin
          state_d = S_DISP_LO;
        end else if (mod_w == 2'b01) begin
          state_d = S_DISP8;
        end else begin
          state_d = S_READ;
        end
      end
      S_DISP_LO: begin
        eff_d   = eff_q + {8'h00, data};
        ip_d    = ip_q + 16'd1;
        state_d = S_DISP_HI;
      end
      S_DISP_HI: begin
        eff_d   = eff_q + {data, 8'h00};
        ip_d    = ip_q + 16'd1;
        state_d = S_READ;
      end
      S_DISP8: begin
        eff_d   = eff_q + {{8{data[7]}}, data};
        ip_d    = ip_q + 16'd1;
        state_d = S_READ;
      end
      S_READ: begin
        for (int k = 0; k < MAX_BYTES; k++) begin
          if (cnt_q == 2'(k)) mem_val_d[8*k +: 8] = data;
        end
        cnt_d = cnt_q + 2'd1;
        if (last_w) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 2'd1;
        if (last_w) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ip_q      <= '0;
      nbytes_q  <= '0;
      ovr_q     <= 1'b0;
      seg_ovr_q <= '0;
      modrm_q   <= '0;
      is_mem_q  <= 1'b0;
      eff_q     <= '0;
      seg_q     <= '0;
      mem_val_q <= '0;
      wb_q      <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ip_q      <= ip_d;
      nbytes_q  <= nbytes_d;
      ovr_q     <= ovr_d;
      seg_ovr_q <= seg_ovr_d;
      modrm_q   <= modrm_d;
      is_mem_q  <= is_mem_d;
      eff_q     <= eff_d;
      seg_q     <= seg_d;
      mem_val_q <= mem_val_d;
      wb_q      <= wb_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
    end
  end

  // While idle the bus address keeps the last driven value.
  assign address = bus_addr_w;
  assign wren    = (state_q == S_WRITE);
  assign out     = (state_q == S_WRITE) ? out_w : 8'h00;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign modrm   = modrm_q;
  assign is_mem  = is_mem_q;
  assign eff     = eff_q;
  assign seg     = seg_q;
  assign mem_val = mem_val_q;
  assign ip_out  = ip_q;

endmodule

// File: tb/tb_modrm_fetch.sv
`timescale 1ns/1ps
module tb_modrm_fetch;
  localparam int AW = 20;
  localparam int MB = 4;
  localparam int DW = 8 * MB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          wb_start = 1'b0;
  logic [1:0]    opsz = 2'd0;
  logic          override = 1'b0;
  logic [15:0]   seg_ovr = 16'h0;
  logic [15:0]   cs = 16'h0, ds = 16'h0, ss = 16'h0, ip_in = 16'h0;
  logic [15:0]   bx = 16'h0, bp = 16'h0, si = 16'h0, di = 16'h0;
  logic [DW-1:0] wb_data = '0;
  logic [7:0]    data;
  logic [AW-1:0] address;
  logic [7:0]    out;
  logic          wren, busy, done;
  logic [7:0]    modrm;
  logic          is_mem;
  logic [15:0]   eff, seg, ip_out;
  logic [DW-1:0] mem_val;

  modrm_fetch #(.ADDR_W(AW), .MAX_BYTES(MB)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .wb_start(wb_start), .opsz(opsz),
    .override(override), .seg_ovr(seg_ovr), .cs(cs), .ds(ds), .ss(ss), .ip_in(ip_in),
    .bx(bx), .bp(bp), .si(si), .di(di), .wb_data(wb_data), .data(data),
    .address(address), .out(out), .wren(wren), .busy(busy), .done(done), .modrm(modrm),
    .is_mem(is_mem), .eff(eff), .seg(seg), .mem_val(mem_val), .ip_out(ip_out)
  );

  always #5 clock = ~clock;

  // Memory image seen on the byte bus; only the stimulus process writes it.
  logic [7:0] mem [0:(1<<AW)-1];
  assign data = mem[address];

  int checks = 0;
  int errors = 0;

  // Expected bus cycles and results, produced by the model.
  logic [AW-1:0] q_addr[$];
  logic          q_wren[$];
  logic [7:0]    q_out[$];
  logic [AW-1:0] wlog_a[$];
  logic [7:0]    wlog_d[$];
  logic          pending = 1'b0, op_done = 1'b0, res_valid = 1'b0;
  logic [7:0]    exp_modrm = 8'h0;
  logic          exp_is_mem = 1'b0;
  logic [15:0]   exp_eff = 16'h0, exp_seg = 16'h0, exp_ip = 16'h0;
  logic [31:0]   exp_mem_val = 32'h0;
  logic [15:0]   m_eff = 16'h0, m_seg = 16'h0;

  logic [7:0]  t_m  [5] = '{8'h02, 8'h86, 8'h4D, 8'h80, 8'h96};
  logic [15:0] t_ip [5] = '{16'h0700, 16'h0710, 16'h0720, 16'h0730, 16'hFFFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] phys(input logic [15:0] s, input logic [15:0] o);
    return AW'((32'(s) * 32'd16 + 32'(o)) % (32'd1 << AW));
  endfunction

  task automatic push(input logic [AW-1:0] a, input logic w, input logic [7:0] o);
    q_addr.push_back(a);
    q_wren.push_back(w);
    q_out.push_back(o);
  endtask

  // Architectural model of one fetch: reads the code stream and operand from mem.
  task automatic model_fetch(input logic [1:0] sz);
    int md, rm, nd, n;
    logic [7:0]  m, b;
    logic [15:0] ip, e, sg, o;
    logic [31:0] v;
    ip = ip_in;
    m = mem[phys(cs, ip)];
    push(phys(cs, ip), 1'b0, 8'h00);
    ip = ip + 16'd1;
    md = int'(m) / 64;
    rm = int'(m) % 8;
    case (rm)
      0: e = bx + si;
      1: e = bx + di;
      2: e = bp + si;
      3: e = bp + di;
      4: e = si;
      5: e = di;
      6: e = (md == 0) ? 16'h0000 : bp;
      default: e = bx;
    endcase
    if (override) sg = seg_ovr;
    else if (md != 3 && (rm == 2 || rm == 3 || (rm == 6 && md != 0))) sg = ss;
    else sg = ds;
    nd = ((md == 0 && rm == 6) || md == 2) ? 2 : ((md == 1) ? 1 : 0);
    for (int k = 0; k < nd; k++) begin
      b = mem[phys(cs, ip)];
      push(phys(cs, ip), 1'b0, 8'h00);
      if (nd == 2) e = e + (16'(b) << (8 * k));
      else         e = e + ((b >= 8'd128) ? (16'(b) - 16'd256) : 16'(b));
      ip = ip + 16'd1;
    end
    n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    v = 32'h0;
    if (md != 3) begin
      for (int i = 0; i < n; i++) begin
        o = e + 16'(i);
        push(phys(sg, o), 1'b0, 8'h00);
        v = v | (32'(mem[phys(sg, o)]) << (8 * i));
      end
    end
    exp_modrm = m; exp_is_mem = (md != 3); exp_eff = e; exp_seg = sg;
    exp_mem_val = v; exp_ip = ip;
    m_eff = e; m_seg = sg;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!op_done && k < 40) begin
      @(posedge clock); #1;
      k++;
    end
    chk({name, "_done_seen"}, 64'(op_done), 64'd1);
    if (!op_done) begin
      pending = 1'b0;
      q_addr.delete(); q_wren.delete(); q_out.delete();
    end
  endtask

  task automatic run_fetch(input logic [1:0] sz, input logic both);
    model_fetch(sz);
    pending = 1'b1; op_done = 1'b0; res_valid = 1'b1;
    opsz = sz; start = 1'b1; wb_start = both;
    @(posedge clock); #1;
    start = 1'b0; wb_start = 1'b0;
    wait_done("fetch");
  endtask

  task automatic run_write(input logic [1:0] sz);
    int n;
    logic [15:0] o;
    n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
    for (int i = 0; i < n; i++) begin
      o = m_eff + 16'(i);
      push(phys(m_seg, o), 1'b1, wb_data[8*i +: 8]);
    end
    pending = 1'b1; op_done = 1'b0; res_valid = 1'b1;  // results must hold through a write
    opsz = sz; wb_start = 1'b1;
    @(posedge clock); #1;
    wb_start = 1'b0;
    wait_done("write");
  endtask

  // Compare process: every bus cycle against the model, results on the done pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if (busy) begin
        chk("done_while_busy", 64'(done), 64'd0);
        if (q_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_busy_cycle: busy=1 at address %0h, expected idle", address);
        end else begin
          logic [AW-1:0] ea;
          logic          ew;
          logic [7:0]    eo;
          ea = q_addr.pop_front(); ew = q_wren.pop_front(); eo = q_out.pop_front();
          chk("bus_address", 64'(address), 64'(ea));
          chk("bus_wren", 64'(wren), 64'(ew));
          if (ew) chk("bus_out", 64'(out), 64'(eo));
          if (wren) begin
            wlog_a.push_back(address);
            wlog_d.push_back(out);
          end
        end
      end else begin
        chk("idle_wren", 64'(wren), 64'd0);
        if (done) begin
          if (!pending) begin
            checks++; errors++;
            $display("FAIL spurious_done: done=1 expected 0");
          end else begin
            pending = 1'b0;
            op_done = 1'b1;
            chk("cycles_left", 64'(q_addr.size()), 64'd0);
            if (res_valid) begin
              chk("modrm", 64'(modrm), 64'(exp_modrm));
              chk("is_mem", 64'(is_mem), 64'(exp_is_mem));
              chk("eff", 64'(eff), 64'(exp_eff));
              chk("seg", 64'(seg), 64'(exp_seg));
              chk("mem_val", 64'(mem_val), 64'(exp_mem_val));
              chk("ip_out", 64'(ip_out), 64'(exp_ip));
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);
    cs = 16'h1000; ds = 16'h0500; ss = 16'h2000;
    bx = 16'h0100; bp = 16'h0010; si = 16'h0020; di = 16'h0004;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_results", {modrm, 7'd0, is_mem, eff, seg, ip_out}, 64'd0);
    chk("rst_mem_val", 64'(mem_val), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Register form: one code-fetch cycle, no operand read.
    mem[20'h10100] = 8'hC3; ip_in = 16'h0100;
    run_fetch(2'd1, 1'b0);
    chk("rf_ip_out", 64'(ip_out), 64'h0101);
    chk("rf_is_mem", 64'(is_mem), 64'd0);
    chk("rf_modrm", 64'(modrm), 64'hC3);
    chk("rf_addr_hold", 64'(address), 64'h10100);

    // [bp+di+disp8] word through SS.
    mem[20'h10200] = 8'h43; mem[20'h10201] = 8'hFE;
    mem[20'h20012] = 8'h5A; mem[20'h20013] = 8'hC6;
    ip_in = 16'h0200;
    run_fetch(2'd1, 1'b0);
    chk("d8_eff", 64'(eff), 64'h0012);
    chk("d8_seg", 64'(seg), 64'h2000);
    chk("d8_mem_val", 64'(mem_val), 64'h0000C65A);
    chk("d8_ip_out", 64'(ip_out), 64'h0202);

    // Writeback of a word to 2000:0012.
    wb_data = 32'h0000ABCD;
    wlog_a.delete(); wlog_d.delete();
    run_write(2'd1);
    chk("wb_count", 64'(wlog_a.size()), 64'd2);
    chk("wb_addr0", 64'(wlog_a[0]), 64'h20012);
    chk("wb_byte0", 64'(wlog_d[0]), 64'hCD);
    chk("wb_byte1", 64'(wlog_d[1]), 64'hAB);

    // start and wb_start together: the fetch wins, no write happens.
    wlog_a.delete(); wlog_d.delete();
    mem[20'h10300] = 8'h00; mem[20'h05120] = 8'h77;
    ip_in = 16'h0300; wb_data = 32'h11223344;
    run_fetch(2'd0, 1'b1);
    repeat (3) begin @(posedge clock); #1; end
    chk("both_mem_val", 64'(mem_val), 64'h77);
    chk("both_no_write", 64'(wlog_a.size()), 64'd0);

    // Direct disp16 dword with segment override.
    mem[20'h10400] = 8'h06; mem[20'h10401] = 8'h34; mem[20'h10402] = 8'h12;
    mem[20'h31234] = 8'h11; mem[20'h31235] = 8'h22; mem[20'h31236] = 8'h33; mem[20'h31237] = 8'h44;
    ip_in = 16'h0400; override = 1'b1; seg_ovr = 16'h3000;
    run_fetch(2'd2, 1'b0);
    override = 1'b0;
    chk("d16_eff", 64'(eff), 64'h1234);
    chk("d16_seg", 64'(seg), 64'h3000);
    chk("d16_mem_val", 64'(mem_val), 64'h44332211);
    chk("d16_ip_out", 64'(ip_out), 64'h0403);

    // Offset wrap: [bx] word at FFFF reads 0FFFF then 00000.
    mem[20'h10500] = 8'h07; mem[20'h0FFFF] = 8'h9A; mem[20'h00000] = 8'hBC;
    bx = 16'hFFFF; ds = 16'h0000; ip_in = 16'h0500;
    run_fetch(2'd1, 1'b0);
    chk("wrap_mem_val", 64'(mem_val), 64'h0000BC9A);
    chk("wrap_addr_hold", 64'(address), 64'h00000);
    bx = 16'h0100; ds = 16'h0500; bp = 16'h1230;

    // Mixed addressing forms, sizes and a code-stream IP wrap.
    for (int k = 0; k < 5; k++) begin
      ip_in = t_ip[k];
      mem[phys(cs, t_ip[k])] = t_m[k];
      mem[phys(cs, t_ip[k] + 16'd1)] = 8'h90 + 8'(k);
      mem[phys(cs, t_ip[k] + 16'd2)] = 8'hF3;
      run_fetch(2'(k % 3), 1'b0);
    end

    // Reset during the second operand byte aborts the read.
    mem[20'h10600] = 8'h00; ip_in = 16'h0600; bp = 16'h0010;
    model_fetch(2'd1);
    pending = 1'b0; res_valid = 1'b0;
    opsz = 2'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wren", 64'(wren), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_address", 64'(address), 64'd0);
    chk("abort_results", {modrm, 7'd0, is_mem, eff, seg, ip_out}, 64'd0);
    chk("abort_mem_val", 64'(mem_val), 64'd0);
    chk("abort_cycles", 64'(q_addr.size()), 64'd0);
    q_addr.delete(); q_wren.delete(); q_out.delete();
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Normal operation after the abort.
    ip_in = 16'h0200;
    run_fetch(2'd1, 1'b0);
    chk("post_eff", 64'(eff), 64'h0012);
    chk("post_mem_val", 64'(mem_val), 64'h0000C65A);

    repeat (2) begin @(posedge clock); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
